// File: rtl/udivision_pkg.sv
// Shared types and helpers for the iterative reciprocal unit.
//   state_t   : controller state encoding (IDLE, BUSY, DONE)
//   recip_sat : all-ones pattern of the requested width (up to 64 bits),
//               used as the clamped result for x <= 1 and on overflow.
package udivision_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Returns a 64-bit word whose low n bits are ones; callers size-cast it.
  function automatic logic [63:0] recip_sat(input int unsigned n);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < n) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/udivision_restore_step.sv
// One radix-2 restoring-division step, purely combinational.
//   rem      : partial remainder (N_BITS_IN+1 bits, always < x on entry)
//   x        : divisor
//   rem_next : remainder after shifting in a zero and conditionally subtracting
//   qbit     : quotient bit produced by this step
module udivision_restore_step #(
  parameter int N_BITS_IN = 12
) (
  input  logic [N_BITS_IN:0]   rem,
  input  logic [N_BITS_IN-1:0] x,
  output logic [N_BITS_IN:0]   rem_next,
  output logic                 qbit
);

  logic [N_BITS_IN:0] t;

  // rem < x < 2^N_BITS_IN, so the shifted value never loses its top bit.
  assign t        = rem << 1;
  assign qbit     = (t >= {1'b0, x});
  assign rem_next = qbit ? (t - {1'b0, x}) : t;

endmodule

// File: rtl/udivision_reciprocal_iter.sv
// Iterative reciprocal: m_tdata = floor (or round-half-up) of 2^N_BITS_OUT / x,
// one quotient bit per cycle via restoring division.
//   clk, rst            : clock, synchronous active-high reset
//   s_tdata/s_tuser     : divisor x and sideband, s_tvalid/s_tready handshake
//   m_tdata/m_tuser     : reciprocal and returned sideband
//   m_div_zero          : result came from x == 0
//   m_saturated         : true result did not fit, clamped to all-ones
//   m_tvalid/m_tready   : result handshake
//   fsm_state           : controller state, for observation
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds data stable while valid is high and ready is low;
// valid never waits on ready. One operand is in flight at a time: s_tready is
// high only in IDLE, and m_tvalid with its data/flags is held in DONE until
// taken.
module udivision_reciprocal_iter
  import udivision_pkg::*;
#(
  parameter int N_BITS_IN  = 12,
  parameter int N_BITS_OUT = 16,
  parameter int USER_W     = 1,
  parameter int ROUND      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_BITS_IN-1:0]  s_tdata,
  input  logic [USER_W-1:0]     s_tuser,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [N_BITS_OUT-1:0] m_tdata,
  output logic [USER_W-1:0]     m_tuser,
  output logic                  m_div_zero,
  output logic                  m_saturated,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output state_t                fsm_state
);

  localparam int CNT_W = $clog2(N_BITS_OUT);
  localparam logic [N_BITS_OUT-1:0] SAT = N_BITS_OUT'(recip_sat(N_BITS_OUT));
  localparam logic [N_BITS_OUT-1:0] ONE = {{(N_BITS_OUT-1){1'b0}}, 1'b1};

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [N_BITS_IN:0]    rem, rem_n;
  logic [N_BITS_OUT-1:0] q, q_n;
  logic [N_BITS_IN-1:0]  x_q, x_n;
  logic [USER_W-1:0]     user_q, user_n;

  logic                  s_tready_n;
  logic [N_BITS_OUT-1:0] m_tdata_n;
  logic [USER_W-1:0]     m_tuser_n;
  logic                  m_div_zero_n, m_saturated_n, m_tvalid_n;

  logic [N_BITS_IN:0]    step_rem;
  logic                  step_qbit;
  logic [N_BITS_OUT-1:0] q_step;
  logic [N_BITS_IN:0]    rem_dbl;
  logic                  round_up;

  assign fsm_state = state;

  udivision_restore_step #(.N_BITS_IN(N_BITS_IN)) u_step (
    .rem      (rem),
    .x        (x_q),
    .rem_next (step_rem),
    .qbit     (step_qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      q           <= '0;
      x_q         <= '0;
      user_q      <= '0;
      s_tready    <= 1'b0;
      m_tdata     <= '0;
      m_tuser     <= '0;
      m_div_zero  <= 1'b0;
      m_saturated <= 1'b0;
      m_tvalid    <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      rem         <= rem_n;
      q           <= q_n;
      x_q         <= x_n;
      user_q      <= user_n;
      s_tready    <= s_tready_n;
      m_tdata     <= m_tdata_n;
      m_tuser     <= m_tuser_n;
      m_div_zero  <= m_div_zero_n;
      m_saturated <= m_saturated_n;
      m_tvalid    <= m_tvalid_n;
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    rem_n         = rem;
    q_n           = q;
    x_n           = x_q;
    user_n        = user_q;
    s_tready_n    = s_tready;
    m_tdata_n     = m_tdata;
    m_tuser_n     = m_tuser;
    m_div_zero_n  = m_div_zero;
    m_saturated_n = m_saturated;
    m_tvalid_n    = m_tvalid;

    q_step        = q;
    q_step[cnt]   = step_qbit;
    // Remainder after the last step decides round-half-up: 2*rem >= x.
    rem_dbl       = step_rem << 1;
    round_up      = (ROUND != 0) && (rem_dbl >= {1'b0, x_q});

    case (state)
      IDLE: begin
        s_tready_n = 1'b1;
        if (s_tvalid && s_tready) begin
          x_n        = s_tdata;
          user_n     = s_tuser;
          rem_n      = {{N_BITS_IN{1'b0}}, 1'b1};
          q_n        = '0;
          cnt_n      = CNT_W'(N_BITS_OUT - 1);
          s_tready_n = 1'b0;
          state_n    = BUSY;
        end
      end

      BUSY: begin
        if (x_q[N_BITS_IN-1:1] == '0) begin
          // x <= 1 spends a single cycle here so its result lands one edge
          // after acceptance; the quotient datapath is bypassed.
          m_tdata_n     = SAT;
          m_tuser_n     = user_q;
          m_saturated_n = 1'b1;
          m_div_zero_n  = ~x_q[0];
          m_tvalid_n    = 1'b1;
          state_n       = DONE;
        end else begin
          rem_n = step_rem;
          q_n   = q_step;
          if (cnt == '0) begin
            m_tuser_n     = user_q;
            m_div_zero_n  = 1'b0;
            m_saturated_n = 1'b0;
            m_tdata_n     = q_step;
            if (round_up) begin
              if (&q_step) begin
                m_tdata_n     = SAT;
                m_saturated_n = 1'b1;
              end else begin
                m_tdata_n = q_step + ONE;
              end
            end
            m_tvalid_n = 1'b1;
            state_n    = DONE;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
      end

      DONE: begin
        if (m_tready) begin
          m_tvalid_n    = 1'b0;
          m_div_zero_n  = 1'b0;
          m_saturated_n = 1'b0;
          s_tready_n    = 1'b1;
          state_n       = IDLE;
        end
      end

      default: begin
        state_n    = IDLE;
        s_tready_n = 1'b0;
        m_tvalid_n = 1'b0;
      end
    endcase
  end

endmodule
